button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 19 +
 rtl/button_debounce_ch.sv | 145 ++++++++++++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Long-press support is enabled by BUTTON_LONG_PRESS_EN.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 20000;
  localparam int LONG_CYCLES_DEF     = 50000000;

  function automatic logic is_down(btn_state_e s);
    return (s == HELD) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, event pulses.
// BUTTON_LONG_PRESS_EN adds the held-time counter and long_press_o.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic button_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_param
    $error("button_debounce_ch: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  logic sync1_q, sync2_q;
  logic btn_dn;

  // Idle level of the pad is high (released)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign btn_dn = ~sync2_q;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_dn) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_dn) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!btn_dn) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_dn) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pressed_o = is_down(state_q);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Parking at HOLD_SAT makes the pulse fire once per press
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (is_down(state_q)) begin
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
        hold_d = HOLD_SAT;
      end else if (hold_q < HOLD_LAST) begin
        hold_d = hold_q + LW'(1);
      end
    end
  end

  assign long_press_o = long_q;
`else
  assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// NBTN independent debounced pushbuttons with press/release pulses.
// Long-press pulses exist only when BUTTON_LONG_PRESS_EN is defined.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NBTN            = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NBTN-1:0] button_i,
  output logic [NBTN-1:0] pressed_o,
  output logic [NBTN-1:0] press_o,
  output logic [NBTN-1:0] release_o,
  output logic [NBTN-1:0] long_press_o
);

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .Clk         (Clk),
      .Reset       (Reset),
      .button_i    (button_i[g]),
      .pressed_o   (pressed_o[g]),
      .press_o     (press_o[g]),
      .release_o   (release_o[g]),
      .long_press_o(long_press_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (D=4, LONG=16, NBTN=2).
// Long-press events are expected only when BUTTON_LONG_PRESS_EN is defined.
module tb_button_conditioner;

  localparam int NBTN = 2;
  localparam int KPRESS = 0;
  localparam int KREL   = 1;
  localparam int KLONG  = 2;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [NBTN-1:0] button_i;
  logic [NBTN-1:0] pressed_o;
  logic [NBTN-1:0] press_o;
  logic [NBTN-1:0] release_o;
  logic [NBTN-1:0] long_press_o;

  button_conditioner #(
    .NBTN           (NBTN),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .button_i    (button_i),
    .pressed_o   (pressed_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_press_o(long_press_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  cyc     = 0;
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int ch, input int at);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk_zero(input string name);
    check({name, " pressed"}, int'(pressed_o), 0);
    check({name, " press"}, int'(press_o), 0);
    check({name, " release"}, int'(release_o), 0);
    check({name, " long"}, int'(long_press_o), 0);
  endtask

  // Monitor: every pulse seen is popped against the scoreboard
  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < NBTN; ch++) begin
          logic b;
          b = (k == KPRESS) ? press_o[ch] :
              (k == KREL)   ? release_o[ch] : long_press_o[ch];
          if (b) begin
            n_total++;
            if (exp_q.size() == 0) begin
              $display("FAIL unexpected pulse: kind %0d ch %0d at cycle %0d, none expected",
                       k, ch, cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.cyc == cyc && e.kind == k && e.ch == ch) n_pass++;
              else $display("FAIL event: got kind %0d ch %0d cycle %0d expected kind %0d ch %0d cycle %0d",
                            k, ch, cyc, e.kind, e.ch, e.cyc);
            end
          end
        end
      end
      for (int ch = 0; ch < NBTN; ch++)
        if (press_o[ch] || release_o[ch])
          check("press/release exclusive", int'(press_o[ch] & release_o[ch]), 0);
    end
  end

  initial begin
    int c;
    int d;
    Reset    = 1'b1;
    button_i = 2'b11;
    step(3);
    chk_zero("reset state");
    Reset = 1'b0;
    step(3);

    // Clean press on channel 0
    c = cyc;
    button_i[0] = 1'b0;
    push(KPRESS, 0, c + 7);
    step(6);
    check("pressed0 before press", int'(pressed_o[0]), 0);
    step(1);
    check("pressed0 at press", int'(pressed_o[0]), 1);
    step(1);

    // Clean release on channel 0
    c = cyc;
    button_i[0] = 1'b1;
    push(KREL, 0, c + 7);
    step(6);
    check("pressed0 before release", int'(pressed_o[0]), 1);
    step(1);
    check("pressed0 at release", int'(pressed_o[0]), 0);
    step(2);

    // Three-cycle glitch is rejected
    button_i[0] = 1'b0;
    step(3);
    button_i[0] = 1'b1;
    step(12);
    check("glitch pressed0", int'(pressed_o[0]), 0);

    // Both channels together, long hold, release glitch on channel 1
    c = cyc;
    button_i = 2'b00;
    push(KPRESS, 0, c + 7);
    push(KPRESS, 1, c + 7);
`ifdef BUTTON_LONG_PRESS_EN
    push(KLONG, 0, c + 23);
    push(KLONG, 1, c + 23);
`endif
    step(12);
    button_i[1] = 1'b1;
    step(2);
    button_i[1] = 1'b0;
    step(4);
    check("pressed both held", int'(pressed_o), 3);
    step(12);
    c = cyc;
    button_i = 2'b11;
    push(KREL, 0, c + 7);
    push(KREL, 1, c + 7);
    step(8);
    check("pressed both released", int'(pressed_o), 0);
    step(2);

    // Reset while held: outputs clear, fresh press after reset
    c = cyc;
    button_i[0] = 1'b0;
    push(KPRESS, 0, c + 7);
    step(10);
    check("pressed0 held before reset", int'(pressed_o[0]), 1);
    Reset = 1'b1;
    step(1);
    chk_zero("reset cycle 1");
    step(1);
    chk_zero("reset cycle 2");
    d = cyc;
    Reset = 1'b0;
    push(KPRESS, 0, d + 7);
    step(6);
    check("pressed0 before re-press", int'(pressed_o[0]), 0);
    step(3);
    check("pressed0 after re-press", int'(pressed_o[0]), 1);
    c = cyc;
    button_i[0] = 1'b1;
    push(KREL, 0, c + 7);
    step(10);

    check("events outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
